exec_pipe: RTL and testbench

EXEC_PIPE -- requirements
Module: exec_pipe

---
 rtl/exec_pkg.sv | 32 +++
 rtl/exec_pipe_mul_seq.sv | 77 +++++++
 rtl/exec_pipe.sv | 164 ++++++++++++++++
 tb/tb_exec_pipe.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared types for the execute stage: ALU opcodes, forwarding selects and
// the iterative multiplier's state encoding.
package exec_pkg;

    typedef enum logic [3:0] {
        OpAdd   = 4'd0,
        OpSub   = 4'd1,
        OpAnd   = 4'd2,
        OpOr    = 4'd3,
        OpXor   = 4'd4,
        OpSll   = 4'd5,
        OpSrl   = 4'd6,
        OpSra   = 4'd7,
        OpSlt   = 4'd8,
        OpMul   = 4'd9,
        OpPassB = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        FwdReg    = 2'b00,
        FwdMem    = 2'b01,
        FwdWb     = 2'b10,
        FwdRegAlt = 2'b11
    } fwd_sel_e;

    typedef enum logic [1:0] {
        MulIdle = 2'd0,
        MulRun  = 2'd1,
        MulDone = 2'd2
    } mul_state_e;

endpackage

// File: rtl/exec_pipe_mul_seq.sv
// Iterative shift-add multiplier producing the low N bits of a*b in N steps.
// Holds the result in DONE until acknowledged; abort returns to IDLE at once.
module mul_seq
    import exec_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic         ack,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] product
);

    localparam int unsigned CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LastStep = CW'(N - 1);

    mul_state_e    state_q, state_d;
    logic [N-1:0]  mcand_q, mplier_q, acc_q;
    logic [CW-1:0] cnt_q;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= MulIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: abort wins from every state
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = MulIdle;
        end else begin
            case (state_q)
                MulIdle: if (start) state_d = MulRun;
                MulRun:  if (cnt_q == LastStep) state_d = MulDone;
                MulDone: if (ack) state_d = MulIdle;
                default: state_d = MulIdle;
            endcase
        end
    end

    // Operand latch on start, then one shift-add step per RUN cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (state_q == MulIdle && start && !abort) begin
            mcand_q  <= a;
            mplier_q <= b;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (state_q == MulRun) begin
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
        end
    end

    assign busy    = (state_q == MulRun);
    assign done    = (state_q == MulDone);
    assign product = acc_q;

endmodule

// File: rtl/exec_pipe.sv
// Execute stage: operand forwarding, ALU, branch resolution and the EX/MEM
// pipeline register. Multiplies are handed to mul_seq and stall upstream.
module exec_pipe
    import exec_pkg::*;
#(
    parameter int unsigned N  = 32,
    parameter int unsigned RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          flush,
    input  logic          valid_in,
    input  logic [N-1:0]  rd1,
    input  logic [N-1:0]  rd2,
    input  logic [N-1:0]  rd3,
    input  logic [N-1:0]  pc,
    input  logic [N-1:0]  imm,
    input  logic [N-1:0]  memFwd,
    input  logic [N-1:0]  wbFwd,
    input  logic [3:0]    aluControl,
    input  logic [1:0]    fwdA,
    input  logic [1:0]    fwdB,
    input  logic [RW-1:0] Ra,
    input  logic [RW-1:0] Rb,
    input  logic [RW-1:0] Rc,
    input  logic          immSrc,
    input  logic          branchFlag,
    input  logic          memWrite,
    input  logic          memToReg,
    input  logic          regWrite,
    output logic          stall,
    output logic          valid_q,
    output logic          memWrite_q,
    output logic          memToReg_q,
    output logic          regWrite_q,
    output logic          branchTaken_q,
    output logic [RW-1:0] Rc_q,
    output logic [N-1:0]  aluRes_q,
    output logic [N-1:0]  storeData_q,
    output logic [N-1:0]  branchTarget_q,
    output logic [3:0]    flags_q
);

    localparam int unsigned SW = $clog2(N);

    alu_op_e      op;
    logic [N-1:0] op_a, fwd_b, op_b;
    logic [N-1:0] alu_res, res;
    logic [N:0]   sum_ext;
    logic         alu_c, alu_v;
    logic [3:0]   flags;
    logic         mul_req, mul_busy, mul_done;
    logic [N-1:0] mul_product;
    logic         kill;

    // Source/read-port fields that this stage carries but does not consume
    logic unused_inputs;
    assign unused_inputs = ^{rd3, Ra, Rb};

    assign op = alu_op_e'(aluControl);

    // Forwarding muxes and immediate select
    always_comb begin
        case (fwd_sel_e'(fwdA))
            FwdMem:  op_a = memFwd;
            FwdWb:   op_a = wbFwd;
            default: op_a = rd1;
        endcase
        case (fwd_sel_e'(fwdB))
            FwdMem:  fwd_b = memFwd;
            FwdWb:   fwd_b = wbFwd;
            default: fwd_b = rd2;
        endcase
        op_b = immSrc ? imm : fwd_b;
    end

    // Single-cycle ALU; MUL is produced by mul_seq, unused opcodes give 0
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        sum_ext = '0;
        case (op)
            OpAdd: begin
                sum_ext = {1'b0, op_a} + {1'b0, op_b};
                alu_res = sum_ext[N-1:0];
                alu_c   = sum_ext[N];
                alu_v   = (op_a[N-1] == op_b[N-1]) && (alu_res[N-1] != op_a[N-1]);
            end
            OpSub: begin
                // Carry is the no-borrow carry out of a + ~b + 1
                sum_ext = {1'b0, op_a} + {1'b0, ~op_b} + {{N{1'b0}}, 1'b1};
                alu_res = sum_ext[N-1:0];
                alu_c   = sum_ext[N];
                alu_v   = (op_a[N-1] != op_b[N-1]) && (alu_res[N-1] != op_a[N-1]);
            end
            OpAnd:   alu_res = op_a & op_b;
            OpOr:    alu_res = op_a | op_b;
            OpXor:   alu_res = op_a ^ op_b;
            OpSll:   alu_res = op_a << op_b[SW-1:0];
            OpSrl:   alu_res = op_a >> op_b[SW-1:0];
            OpSra:   alu_res = $signed(op_a) >>> op_b[SW-1:0];
            OpSlt:   alu_res = {{(N-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            OpPassB: alu_res = op_b;
            default: alu_res = '0;
        endcase
    end

    // Result select and flags; a finished multiply reports Z and N only
    always_comb begin
        res   = mul_done ? mul_product : alu_res;
        flags = {(res == '0), res[N-1], alu_c & ~mul_done, alu_v & ~mul_done};
    end

    assign mul_req = valid_in && (op == OpMul);

    mul_seq #(
        .N (N)
    ) u_mul_seq (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_req & ~flush),
        .abort   (flush),
        .ack     (en),
        .a       (op_a),
        .b       (op_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // Hold upstream while a multiply is being accepted or is running
    assign stall = rst & (mul_busy | (mul_req & ~mul_done));
    assign kill  = flush | stall | ~valid_in;

    // EX/MEM register: flush forces a bubble even when en is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q        <= 1'b0;
            memWrite_q     <= 1'b0;
            memToReg_q     <= 1'b0;
            regWrite_q     <= 1'b0;
            branchTaken_q  <= 1'b0;
            Rc_q           <= '0;
            aluRes_q       <= '0;
            storeData_q    <= '0;
            branchTarget_q <= '0;
            flags_q        <= '0;
        end else if (flush || en) begin
            valid_q        <= ~kill;
            memWrite_q     <= memWrite & ~kill;
            memToReg_q     <= memToReg & ~kill;
            regWrite_q     <= regWrite & ~kill;
            branchTaken_q  <= branchFlag & flags[3] & ~kill;
            Rc_q           <= Rc;
            aluRes_q       <= res;
            storeData_q    <= fwd_b;
            branchTarget_q <= pc + imm;
            flags_q        <= flags;
        end
    end

endmodule

// File: tb/tb_exec_pipe.sv
// Directed scoreboard bench for exec_pipe at N=8.
module tb_exec_pipe;

    localparam int unsigned N  = 8;
    localparam int unsigned RW = 4;

    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_SLL = 4'd5;
    localparam logic [3:0] A_SRL = 4'd6, A_SRA = 4'd7, A_SLT = 4'd8, A_MUL = 4'd9;
    localparam logic [3:0] A_PASSB = 4'd10, A_RSV = 4'd13;

    logic          clk, rst, en, flush, valid_in;
    logic [N-1:0]  rd1, rd2, rd3, pc, imm, memFwd, wbFwd;
    logic [3:0]    aluControl;
    logic [1:0]    fwdA, fwdB;
    logic [RW-1:0] Ra, Rb, Rc;
    logic          immSrc, branchFlag, memWrite, memToReg, regWrite;
    logic          stall, valid_q, memWrite_q, memToReg_q, regWrite_q, branchTaken_q;
    logic [RW-1:0] Rc_q;
    logic [N-1:0]  aluRes_q, storeData_q, branchTarget_q;
    logic [3:0]    flags_q;

    typedef struct {
        string      tag;
        logic       valid;
        logic [7:0] res;
        logic [3:0] flags;
        logic       bt;
        logic [7:0] tgt;
        logic [7:0] sd;
        bit         full;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   edges;

    exec_pipe #(
        .N  (N),
        .RW (RW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .flush          (flush),
        .valid_in       (valid_in),
        .rd1            (rd1),
        .rd2            (rd2),
        .rd3            (rd3),
        .pc             (pc),
        .imm            (imm),
        .memFwd         (memFwd),
        .wbFwd          (wbFwd),
        .aluControl     (aluControl),
        .fwdA           (fwdA),
        .fwdB           (fwdB),
        .Ra             (Ra),
        .Rb             (Rb),
        .Rc             (Rc),
        .immSrc         (immSrc),
        .branchFlag     (branchFlag),
        .memWrite       (memWrite),
        .memToReg       (memToReg),
        .regWrite       (regWrite),
        .stall          (stall),
        .valid_q        (valid_q),
        .memWrite_q     (memWrite_q),
        .memToReg_q     (memToReg_q),
        .regWrite_q     (regWrite_q),
        .branchTaken_q  (branchTaken_q),
        .Rc_q           (Rc_q),
        .aluRes_q       (aluRes_q),
        .storeData_q    (storeData_q),
        .branchTarget_q (branchTarget_q),
        .flags_q        (flags_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] fa, input logic [1:0] fb, input logic [7:0] mf,
                         input logic [7:0] wf, input logic [7:0] im, input logic is,
                         input logic bf, input logic [7:0] p, input logic v);
        aluControl = op;  rd1 = a;  rd2 = b;  fwdA = fa;  fwdB = fb;
        memFwd = mf;  wbFwd = wf;  imm = im;  immSrc = is;  branchFlag = bf;
        pc = p;  valid_in = v;  rd3 = 8'hA5;  Ra = 4'd1;  Rb = 4'd2;  Rc = 4'd3;
        regWrite = 1'b1;  memWrite = 1'b0;  memToReg = 1'b0;
    endtask

    task automatic push(input string tag, input logic v, input logic [7:0] r,
                        input logic [3:0] f, input logic bt, input logic [7:0] tg,
                        input logic [7:0] sd, input bit full);
        exp_t e;
        e.tag = tag;  e.valid = v;  e.res = r;  e.flags = f;
        e.bt = bt;  e.tgt = tg;  e.sd = sd;  e.full = full;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL sb_empty observed=0 expected=1");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({e.tag, ".valid"}, valid_q, e.valid);
            chk({e.tag, ".regwr"}, regWrite_q, e.valid);
            if (e.full) begin
                chk({e.tag, ".res"}, aluRes_q, e.res);
                chk({e.tag, ".flags"}, flags_q, e.flags);
                chk({e.tag, ".btaken"}, branchTaken_q, e.bt);
                chk({e.tag, ".btarget"}, branchTarget_q, e.tgt);
                chk({e.tag, ".sdata"}, storeData_q, e.sd);
                chk({e.tag, ".rc"}, Rc_q, 4'd3);
            end
        end
    endtask

    task automatic step_check();
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic wait_stall_low(input int budget, output int n);
        n = 0;
        while (stall && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        rst = 1'b0;  en = 1'b1;  flush = 1'b0;
        drive(A_ADD, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("reset.res", aluRes_q, 0);
        chk("reset.valid", valid_q, 0);
        chk("reset.flags", flags_q, 0);
        chk("reset.stall", stall, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Single-cycle operations
        @(negedge clk);
        drive(A_ADD, 8'd2, 8'd2, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1);
        push("add", 1, 8'd4, 4'b0000, 0, 8'd0, 8'd2, 1);
        step_check();

        @(negedge clk);
        drive(A_SUB, 8'd0, 8'd0, 2'b01, 2'b10, 8'd5, 8'd3, 0, 0, 0, 0, 1);
        push("sub_fwd", 1, 8'd2, 4'b0010, 0, 8'd0, 8'd3, 1);
        step_check();

        @(negedge clk);
        drive(A_ADD, 8'd127, 8'd1, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 1);
        push("add_ovf", 1, 8'h80, 4'b0101, 0, 8'd0, 8'd1, 1);
        step_check();

        // en low holds the register; then the same branch advances
        @(negedge clk);
        en = 1'b0;
        drive(A_SUB, 8'd6, 8'd6, 2'b00, 2'b00, 0, 0, 8'd4, 0, 1, 8'd16, 1);
        push("hold", 1, 8'h80, 4'b0101, 0, 8'd0, 8'd1, 1);
        step_check();
        @(negedge clk);
        en = 1'b1;
        push("branch", 1, 8'd0, 4'b1010, 1, 8'd20, 8'd6, 1);
        step_check();

        @(negedge clk);
        drive(A_ADD, 8'hFF, 8'h01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1);
        push("add_carry", 1, 8'h00, 4'b1010, 0, 8'd0, 8'h01, 1);
        step_check();

        @(negedge clk);
        drive(A_AND, 8'hF0, 8'h3C, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1);
        push("and", 1, 8'h30, 4'b0000, 0, 8'd0, 8'h3C, 1);
        step_check();

        @(negedge clk);
        drive(A_SLL, 8'h81, 8'hFF, 2'b00, 2'b00, 0, 0, 8'd3, 1, 0, 0, 1);
        push("sll_imm", 1, 8'h08, 4'b0000, 0, 8'd3, 8'hFF, 1);
        step_check();

        @(negedge clk);
        drive(A_SRA, 8'h80, 8'd2, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1);
        push("sra", 1, 8'hE0, 4'b0100, 0, 8'd0, 8'd2, 1);
        step_check();

        @(negedge clk);
        drive(A_SRL, 8'h80, 8'd9, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1);
        push("srl_amt_wrap", 1, 8'h40, 4'b0000, 0, 8'd0, 8'd9, 1);
        step_check();

        @(negedge clk);
        drive(A_SLT, 8'hFF, 8'h01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1);
        push("slt", 1, 8'h01, 4'b0000, 0, 8'd0, 8'h01, 1);
        step_check();

        @(negedge clk);
        drive(A_PASSB, 8'h55, 8'h00, 2'b00, 2'b00, 0, 0, 8'h90, 0, 1, 8'h80, 1);
        push("passb_tgt_wrap", 1, 8'h00, 4'b1000, 1, 8'h10, 8'h00, 1);
        step_check();

        @(negedge clk);
        drive(A_RSV, 8'd5, 8'd3, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1);
        push("op13", 1, 8'h00, 4'b1000, 0, 8'd0, 8'd3, 1);
        step_check();

        @(negedge clk);
        drive(A_ADD, 8'd1, 8'd1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        push("bubble", 0, 8'd0, 4'b0000, 0, 8'd0, 8'd0, 0);
        step_check();

        // Multiply 7x9: stall for 9 cycles, product on the 10th edge
        @(negedge clk);
        drive(A_MUL, 8'd7, 8'd9, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1);
        push("mul_7x9", 1, 8'd63, 4'b0000, 0, 8'd0, 8'd9, 1);
        #1;
        chk("mul.stall_rise", stall, 1);
        wait_stall_low(40, edges);
        chk("mul.stall_edges", edges, 9);
        chk("mul.bubble", valid_q, 0);
        step_check();

        @(negedge clk);
        drive(A_MUL, 8'd20, 8'd20, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1);
        push("mul_trunc", 1, 8'h90, 4'b0100, 0, 8'd0, 8'd20, 1);
        wait_stall_low(40, edges);
        chk("mul2.stall_edges", edges, 9);
        step_check();

        // en low during RUN: multiplier keeps going, DONE waits for en
        @(negedge clk);
        drive(A_MUL, 8'd5, 8'd6, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1);
        push("mul_en_low", 1, 8'd30, 4'b0000, 0, 8'd0, 8'd6, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        en = 1'b0;
        wait_stall_low(40, edges);
        chk("mul3.stall_edges", edges, 8);
        @(posedge clk);
        #1;
        chk("mul3.done_hold", valid_q, 0);
        chk("mul3.done_stall", stall, 0);
        @(negedge clk);
        en = 1'b1;
        step_check();

        // Flush during RUN aborts the multiply
        @(negedge clk);
        drive(A_MUL, 8'd3, 8'd3, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        chk("flush.stall", stall, 0);
        chk("flush.valid", valid_q, 0);
        @(negedge clk);
        flush = 1'b0;
        drive(A_ADD, 8'd0, 8'd0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("flush.no_product", aluRes_q, 0);
            chk("flush.no_stall", stall, 0);
        end

        // Asynchronous reset in the middle of a multiply
        @(negedge clk);
        drive(A_MUL, 8'd7, 8'd9, 2'b00, 2'b00, 0, 0, 8'd4, 0, 0, 8'd16, 1);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("rst.res", aluRes_q, 0);
        chk("rst.sdata", storeData_q, 0);
        chk("rst.btarget", branchTarget_q, 0);
        chk("rst.stall", stall, 0);
        chk("rst.valid", valid_q, 0);
        @(negedge clk);
        drive(A_ADD, 8'd1, 8'd1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1);
        push("add_after_rst", 1, 8'd2, 4'b0000, 0, 8'd0, 8'd1, 1);
        rst = 1'b1;
        step_check();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
